// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver clocked by the system clock.
// The asynchronous rx line is synchronized with two flops. A down-counting bit
// timer finds the centre of each bit, and each frame is delivered with a
// one-cycle data_ready strobe.
// Optional feature: define UART_RX_PARITY_EN to add an even-parity bit after
// the data bits and a parity_error output.
//
// state     | meaning
// IDLE      | line idle, waiting for rx_s low
// START     | timing to start-bit centre; a high sample there means a glitch
// DATA      | sampling DATA_BITS data bits, LSB first
// PARITY    | sampling the even-parity bit (UART_RX_PARITY_EN only)
// STOP      | timing to stop-bit centre and sampling it
// DONE      | publishing data_out / data_ready / error flags
// WAIT_HIGH | stop bit was 0; hold off until the line returns high
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_ready,
  output logic                 frame_error,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_error,
`endif
  output logic                 busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] BIT_LOAD = TW'(CLKS_PER_BIT - 1);
  // The cycle in IDLE that detects rx_s low already counts as the first
  // cycle of the half bit. The remaining wait is therefore CLKS_PER_BIT/2-1
  // cycles, and the timer is loaded with one less than that.
  localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 2);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    DONE,
    WAIT_HIGH
  } state_t;

  state_t               state;
  logic                 rx_meta;
  logic                 rx_s;
  logic [TW-1:0]        timer;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 stop_bit;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit;
`endif

  // Two-flop synchronizer for the asynchronous rx pin; idles high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Frame FSM with bit timer, shift register and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      timer        <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      stop_bit     <= 1'b0;
      data_out     <= '0;
      data_ready   <= 1'b0;
      frame_error  <= 1'b0;
      busy         <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit      <= 1'b0;
      parity_error <= 1'b0;
`endif
    end else begin
      data_ready   <= 1'b0;
      frame_error  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error <= 1'b0;
`endif
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (!rx_s) begin
            state   <= START;
            busy    <= 1'b1;
            timer   <= HALF_LOAD;
            bit_idx <= '0;
          end
        end
        START: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state   <= DATA;
            timer   <= BIT_LOAD;
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else begin
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            timer <= BIT_LOAD;
            if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else begin
            par_bit <= rx_s;
            timer   <= BIT_LOAD;
            state   <= STOP;
          end
        end
`endif
        STOP: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else begin
            stop_bit <= rx_s;
            state    <= DONE;
          end
        end
        DONE: begin
          data_out     <= shreg;
          data_ready   <= 1'b1;
          frame_error  <= ~stop_bit;
`ifdef UART_RX_PARITY_EN
          parity_error <= (^shreg) ^ par_bit;
`endif
          if (stop_bit) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= WAIT_HIGH;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Testbench for uart_rx_core: a table of frames, hand-written corner cases and
// random frames, all checked against expectations derived from the frame
// contents.
module tb_uart_rx_core;

  localparam int C = 16;
  localparam int D = 8;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 2 + (D + 1) * C + C / 2 + 1 + C;
`else
  localparam int LAT = 2 + (D + 1) * C + C / 2 + 1;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         rx = 1'b1;
  logic [D-1:0] data_out;
  logic         data_ready;
  logic         frame_error;
  logic         parity_error;
  logic         busy;

  uart_rx_core #(.CLKS_PER_BIT(C), .DATA_BITS(D)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .data_out    (data_out),
    .data_ready  (data_ready),
    .frame_error (frame_error),
`ifdef UART_RX_PARITY_EN
    .parity_error(parity_error),
`endif
    .busy        (busy)
  );

`ifndef UART_RX_PARITY_EN
  assign parity_error = 1'b0;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int         cyc;
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } obs_t;
  obs_t obs[$];

  // Each cycle with data_ready high becomes one observation.
  always @(negedge clk) begin : mon
    obs_t o;
    if (data_ready) begin
      o.cyc = cyc;
      o.d   = data_out;
      o.fe  = frame_error;
      o.pe  = parity_error;
      obs.push_back(o);
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drives one frame. It must be called at a rising edge and it returns at a
  // rising edge. t0 is the edge after which rx fell.
  task automatic send_frame(input logic [7:0] d, input logic stopb, input logic parb,
                            output int t0);
    #1 rx = 1'b0;
    t0 = cyc;
    repeat (C) @(posedge clk);
    for (int i = 0; i < D; i++) begin
      #1 rx = d[i];
      repeat (C) @(posedge clk);
    end
`ifdef UART_RX_PARITY_EN
    #1 rx = parb;
    repeat (C) @(posedge clk);
`else
    if (parb === 1'bx) rx = 1'b1;
`endif
    #1 rx = stopb;
    repeat (C) @(posedge clk);
  endtask

  task automatic check_frame(input string nm, input logic [7:0] ed, input logic efe,
                             input logic epe, input int t0);
    obs_t o;
    check({nm, " pulses"}, obs.size(), 1);
    if (obs.size() > 0) begin
      o = obs.pop_front();
      check({nm, " data"}, o.d, ed);
      check({nm, " frame_error"}, o.fe, efe);
      check({nm, " latency"}, o.cyc - t0, LAT);
`ifdef UART_RX_PARITY_EN
      check({nm, " parity_error"}, o.pe, epe);
`else
      if (epe === 1'bx) check({nm, " parity_error"}, o.pe, 1'b0);
`endif
    end
    obs.delete();
  endtask

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic [7:0] exp_d;
    logic       exp_pe;
    int         gap;
  } vec_t;

  initial begin : wd
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t       tbl[7];
    int         t0;
    logic [7:0] rd;
    logic       rs;
    logic       rp;

    tbl[0] = '{8'hA5, 1'b0, 8'hA5, 1'b0, 0};
    tbl[1] = '{8'h00, 1'b0, 8'h00, 1'b0, 0};
    tbl[2] = '{8'hFF, 1'b0, 8'hFF, 1'b0, 5};
    tbl[3] = '{8'h07, 1'b1, 8'h07, 1'b0, 3};
    tbl[4] = '{8'h07, 1'b0, 8'h07, 1'b1, 3};
    tbl[5] = '{8'h5A, 1'b0, 8'h5A, 1'b0, 2};
    tbl[6] = '{8'h80, 1'b1, 8'h80, 1'b0, 1};

    #15;
    check("reset data_out", data_out, 8'h00);
    check("reset data_ready", data_ready, 1'b0);
    check("reset frame_error", frame_error, 1'b0);
    check("reset busy", busy, 1'b0);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);

    for (int i = 0; i < 7; i++) begin
      send_frame(tbl[i].d, 1'b1, tbl[i].p, t0);
      check_frame($sformatf("tbl%0d", i), tbl[i].exp_d, 1'b0, tbl[i].exp_pe, t0);
      check($sformatf("tbl%0d busy idle", i), busy, 1'b0);
      repeat (tbl[i].gap) @(posedge clk);
    end

    // Stop bit 0, then the line stays low.
    send_frame(8'h3C, 1'b0, 1'b0, t0);
    check_frame("break 3C", 8'h3C, 1'b1, 1'b0, t0);
    repeat (40) @(posedge clk);
    check("break no 2nd frame", obs.size(), 0);
    check("break busy held", busy, 1'b1);
    #1 rx = 1'b1;
    repeat (4) @(posedge clk);
    check("break busy released", busy, 1'b0);

    // Start-bit glitch shorter than half a bit.
    repeat (5) @(posedge clk);
    #1 rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx = 1'b1;
    repeat (30) @(posedge clk);
    check("glitch pulses", obs.size(), 0);
    check("glitch data_out kept", data_out, 8'h3C);
    check("glitch busy", busy, 1'b0);

    // Reset during data bit 4 of 0x81.
    fork
      send_frame(8'h81, 1'b1, 1'b0, t0);
      begin
        repeat (C * 5 + C / 2) @(posedge clk);
        check("mid-frame busy", busy, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("async reset data_out", data_out, 8'h00);
        check("async reset busy", busy, 1'b0);
        check("async reset data_ready", data_ready, 1'b0);
      end
    join
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    check("reset frame discarded", obs.size(), 0);
    check("after reset data_out", data_out, 8'h00);
    send_frame(8'h7E, 1'b1, 1'b0, t0);
    check_frame("post-reset 7E", 8'h7E, 1'b0, 1'b0, t0);

    // Random frames checked against the frame contents.
    for (int k = 0; k < 16; k++) begin
      rd = 8'($urandom);
      rs = ($urandom_range(0, 7) != 0);
      rp = 1'($urandom_range(0, 1));
      send_frame(rd, rs, rp, t0);
      check_frame($sformatf("rand%0d", k), rd, ~rs, (^rd) ^ rp, t0);
      if (!rs) begin
        repeat ($urandom_range(0, 30)) @(posedge clk);
        #1 rx = 1'b1;
        repeat (4 + $urandom_range(0, 5)) @(posedge clk);
      end else begin
        repeat ($urandom_range(0, 20)) @(posedge clk);
      end
    end

    repeat (C * 2) @(posedge clk);
    check("final no stray pulses", obs.size(), 0);
    check("final busy", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- Standalone UART receiver core: the receive end of the 8N1 serial link driven by the team's UART transmit side.
- Samples the asynchronous `rx` line on the single system clock, reconstructs each frame and presents the byte with a one-cycle `data_ready` strobe.
- Sits behind the `rx` pin of each UART instance. Replaces the separate `clk_uart` domain: an internal bit-timing counter derives bit timing from `clk`.

Parameters:
- CLKS_PER_BIT, 16: system clocks per serial bit; legal range 4 to 65535.
- DATA_BITS, 8: data bits per frame, LSB first; legal range 5 to 8.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; 0 forces all state to reset values immediately.
- rx  input  1  asynchronous serial line; idle high.
- data_out  output  DATA_BITS  last received byte; holds its value until the next completed frame.
- data_ready  output  1  one-clk pulse when data_out is updated.
- frame_error  output  1  pulses with data_ready when the stop bit sampled 0.
- busy  output  1  high from start-bit detection until return to IDLE.

Behaviour:
- Reset values:
  - data_out = 0, data_ready = 0, frame_error = 0, busy = 0.
  - Synchronizer flops = 1, state = IDLE, counters = 0.
- rx passes through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
- State IDLE: busy = 0. When rx_s = 0, go to START and clear the bit counter.
- State START:
  - Count CLKS_PER_BIT/2 cycles (integer division), then sample rx_s at the bit centre.
  - Sample 0: go to DATA with the bit counter cleared.
  - Sample 1: glitch. Go to IDLE with no output activity.
- State DATA:
  - Every CLKS_PER_BIT cycles, sample rx_s into the shift register, LSB first.
  - After DATA_BITS samples, go to STOP.
- State STOP: after CLKS_PER_BIT cycles, sample rx_s.
  - Next cycle: load data_out from the shift register and pulse data_ready for exactly one clk.
  - Set frame_error = NOT(sampled stop bit) in that same cycle.
  - Stop bit = 1: return to IDLE. This allows back-to-back frames; the next start bit may begin half a bit after the stop centre.
  - Stop bit = 0 (break or framing fault): go to WAIT_HIGH.
- State WAIT_HIGH: busy stays 1 until rx_s = 1, then go to IDLE. This prevents a held-low line from being decoded as repeated 0x00 frames.
- Latency: data_ready rises 1 clk after the mid-stop sample, which is 2 sync cycles + ((DATA_BITS+1)×CLKS_PER_BIT + CLKS_PER_BIT/2) + 1 cycles after the start-bit falling edge on rx.
- data_out is never partially updated: the shift register is internal and copied only in the data_ready cycle.
- Reset asserted mid-frame: the frame is discarded, no data_ready, and all outputs take reset values immediately. After release, the receiver needs rx_s high-then-low to start a new frame.
- Counter width: ceil(log2(CLKS_PER_BIT)) bits. It wraps only through an explicit clear at each bit boundary.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - A PARITY state follows DATA and samples one even-parity bit at its centre.
  - An extra output port `parity_error` (1 bit, reset 0) pulses with data_ready when the XOR of the data bits and the parity bit is 1.
  - data_out still updates on a parity error.
  - Latency grows by CLKS_PER_BIT.
- When undefined: no PARITY state and no parity_error port; the frame is 8N1.

Test Plan:
- CLKS_PER_BIT=16, send 0xA5 (start, 1,0,1,0,0,1,0,1 LSB first, stop=1) -> data_out=0xA5; data_ready high for exactly 1 clk, 2+152+1 cycles after the start edge; frame_error=0; busy returns to 0.
- rx low for 4 clks, then high -> START sample reads 1; no data_ready; state back to IDLE; data_out unchanged.
- Send 0x3C with stop bit = 0, hold rx low 40 clks, then high -> data_out=0x3C with data_ready=1 and frame_error=1; no second frame while low; busy drops only after rx returns high.
- Back-to-back 0x00 then 0xFF, with the second start bit immediately after the first stop bit -> two data_ready pulses with data_out 0x00 then 0xFF, frame_error=0 both times.
- Assert reset low during data bit 4 of 0x81, release, then send 0x7E -> no pulse for 0x81; outputs 0 during reset; then data_out=0x7E.
- With UART_RX_PARITY_EN, send 0x07 with parity bit 1, then 0x07 with parity bit 0 -> parity_error=0 on the first frame and 1 on the second; data_out=0x07 both times.
